sgdmac_wr_engine: RTL
=====================

# sgdmac_wr_engine

AXI3 write engine of the scatter-gather DMA. Pops one 48-bit write command per start pulse from the write-command FIFO, splits it into INCR bursts of at most 16 words that never cross a 4 KB boundary, and drains the shared 32-bit data buffer onto the AW/W/B channels. Sits downstream of the command FIFO and data buffer. Reports idle back to the top level for completion detection.

## Interface
- FIFO_DEPTH, 128, data-buffer depth; sets the fifo_cnt_i width to $clog2(FIFO_DEPTH)+1.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous and active-high; all state clears immediately.
- start_i  in  1  one-cycle pulse; cmd_i is valid in the same cycle. Ignored unless idle.
- cmd_i  in  48  [47:16] destination byte address (word-aligned); [15:0] byte length (bits [1:0] ignored).
- done_o  out  1  high while idle.
- err_o  out  1  sticky: any bresp != 0 since the last accepted start.
- fifo_empty_i  in  1  data buffer empty.
- fifo_cnt_i  in  $clog2(FIFO_DEPTH)+1  words in the data buffer.
- fifo_rdata_i  in  32  show-ahead head word.
- fifo_rden_o  out  1  pop the data buffer.
- awid_o, awaddr_o, awlen_o, awsize_o, awburst_o, awvalid_o  out  4/32/4/3/2/1  AW channel.
- awready_i  in  1  AW channel.
- wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o  out  4/32/4/1/1  W channel.
- wready_i  in  1  W channel.
- bresp_i, bvalid_i  in  2/1  B channel.
- bready_o  out  1  B channel.

## Operation
- Constant outputs:
  - awid_o = wid_o = 4'd0.
  - awsize_o = 3'b010 (4 bytes).
  - awburst_o = 2'b01 (INCR).
  - wstrb_o = 4'hF.
- Registers:
  - addr: 32 bits.
  - rem: word count, 14 bits.
  - beats: 5 bits, range 1..16.
  - bcnt: beat counter, 4 bits.
  - state.
- State IDLE (done_o=1):
  - On start_i: latch addr=cmd_i[47:16], rem=cmd_i[15:2], clear err_o, go to PLAN.
- State PLAN:
  - If rem==0, go to IDLE.
  - Otherwise beats = min(16, rem, (4096 - addr[11:0])/4).
  - Wait until fifo_cnt_i >= beats.
  - Then register awaddr_o=addr, awlen_o=beats-1, assert awvalid_o, go to AW.
- State AW:
  - Hold all AW outputs stable until awready_i.
  - On the handshake: deassert awvalid_o, clear bcnt, go to W.
- State W:
  - wvalid_o = ~fifo_empty_i; wdata_o = fifo_rdata_i.
  - wlast_o = (bcnt == awlen_o).
  - fifo_rden_o = wvalid_o & wready_i.
  - bcnt increments on each handshake.
  - The handshake with wlast_o goes to B.
- State B:
  - bready_o = 1.
  - On bvalid_i: err_o |= (bresp_i != 0); addr += beats*4 (32-bit wrap); rem -= beats; go to PLAN.
- W data is never issued before its AW handshake. A burst's data must be buffered before its AW is issued (no bus hold on empty buffer). wvalid_o may still drop if fifo_empty_i rises.
- Errors do not abort the transfer; the remaining bursts still run.

## Timing
- Reset values:
  - State IDLE; done_o=1.
  - awvalid_o, wvalid_o, wlast_o, bready_o, fifo_rden_o, err_o all 0.
  - awaddr_o = 0, awlen_o = 0.
- Latency with data already buffered:
  - start_i in cycle 0 -> PLAN in cycle 1 -> awvalid_o high in cycle 2.
  - First wvalid_o is one cycle after the AW handshake.
- Zero length: start_i in cycle 0 -> done_o low in cycle 1 only -> high in cycle 2. No AXI traffic.
- Length register width: 14 bits covers the maximum 16383 words.
- The 4 KB split uses only addr[11:0]; a boundary-aligned address gives 1024 words available.
- start_i while not idle: ignored, no latch.
- Simultaneous AW handshake and bvalid_i: impossible by construction (strictly one outstanding burst).
- bvalid_i outside state B: ignored (bready_o=0).
- Reset mid-burst: the engine returns to IDLE immediately with all valids deasserted. Words already popped are lost; the data buffer is not touched.

## Test plan
- Single burst, buffer preloaded with 16 words:
  - Stimulus: addr 0x0000_1000, len 64.
  - Required: one AW with awaddr 0x1000, awlen 15; 16 W beats; wlast on beat 16; bready; done_o rises one cycle after bvalid.
- 4 KB crossing:
  - Stimulus: addr 0x0000_0FF8, len 32.
  - Required: AW 0x0FF8 awlen 1, then AW 0x1000 awlen 5; 8 beats total; data order preserved.
- Buffer starvation:
  - Stimulus: len 64; fifo_cnt_i held at 10, then raised to 16 at cycle 40.
  - Required: awvalid_o stays low until fifo_cnt_i>=16, then rises two cycles later.
- W backpressure:
  - Stimulus: wready_i toggled 1,0,0,1 repeatedly.
  - Required: fifo_rden_o only on handshake cycles; wdata_o stable while stalled; exactly 16 pops.
- Error and zero length:
  - Stimulus: bresp 2'b10 on the first of two bursts.
  - Required: err_o goes high and the second burst still issues.
  - Stimulus: next start with len 0.
  - Required: err_o clears, no AW, done_o low for exactly one cycle.
- Reset mid-burst:
  - Stimulus: assert rst during beat 5.
  - Required: outputs reach reset values asynchronously. The next start then runs a clean burst.

Source files
------------

// File: rtl/sgdmac_wr_engine.sv
// sgdmac_wr_engine: AXI3 write engine that splits each command into
// 4KB-safe INCR bursts of up to 16 words, fed from the shared data buffer.
module sgdmac_wr_engine #(
  parameter int FIFO_DEPTH = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [47:0]                 cmd_i,
  output logic                        done_o,
  output logic                        err_o,
  input  logic                        fifo_empty_i,
  input  logic [$clog2(FIFO_DEPTH):0] fifo_cnt_i,
  input  logic [31:0]                 fifo_rdata_i,
  output logic                        fifo_rden_o,
  output logic [3:0]                  awid_o,
  output logic [31:0]                 awaddr_o,
  output logic [3:0]                  awlen_o,
  output logic [2:0]                  awsize_o,
  output logic [1:0]                  awburst_o,
  output logic                        awvalid_o,
  input  logic                        awready_i,
  output logic [3:0]                  wid_o,
  output logic [31:0]                 wdata_o,
  output logic [3:0]                  wstrb_o,
  output logic                        wlast_o,
  output logic                        wvalid_o,
  input  logic                        wready_i,
  input  logic [1:0]                  bresp_i,
  input  logic                        bvalid_i,
  output logic                        bready_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  typedef enum logic [2:0] {IDLE, PLAN, AW, W, B} state_t;
  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d, awaddr_q, awaddr_d;
  logic [13:0]   rem_q, rem_d;
  logic [4:0]    beats_q, beats_d, rem_cap, beats_c;
  logic [3:0]    bcnt_q, bcnt_d, awlen_q, awlen_d;
  logic          awvalid_q, awvalid_d, err_q, err_d;
  logic [CW-1:0] cnt_q;
  logic [10:0]   avail;
  assign awid_o      = 4'd0;
  assign wid_o       = 4'd0;
  assign awsize_o    = 3'b010;
  assign awburst_o   = 2'b01;
  assign wstrb_o     = 4'hF;
  assign awaddr_o    = awaddr_q;
  assign awlen_o     = awlen_q;
  assign awvalid_o   = awvalid_q;
  assign err_o       = err_q;
  assign done_o      = state_q == IDLE;
  assign bready_o    = state_q == B;
  assign wvalid_o    = (state_q == W) & ~fifo_empty_i;
  assign wdata_o     = fifo_rdata_i;
  assign wlast_o     = (state_q == W) & (bcnt_q == awlen_q);
  assign fifo_rden_o = wvalid_o & wready_i;
  always_comb begin
    avail     = 11'd1024 - {1'b0, addr_q[11:2]};
    rem_cap   = rem_q > 14'd16 ? 5'd16 : rem_q[4:0];
    beats_c   = {6'd0, rem_cap} > avail ? avail[4:0] : rem_cap;
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    beats_d   = beats_q;
    bcnt_d    = bcnt_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awvalid_d = awvalid_q;
    err_d     = err_q;
    case (state_q)
      IDLE: if (start_i) begin
        addr_d  = cmd_i[47:16];
        rem_d   = cmd_i[15:2];
        err_d   = 1'b0;
        state_d = PLAN;
      end
      PLAN: if (rem_q == 14'd0) state_d = IDLE;
      else if (cnt_q >= CW'(beats_c)) begin
        beats_d   = beats_c;
        awaddr_d  = addr_q;
        awlen_d   = 4'(beats_c - 5'd1);
        awvalid_d = 1'b1;
        state_d   = AW;
      end
      AW: if (awready_i) begin
        awvalid_d = 1'b0;
        bcnt_d    = 4'd0;
        state_d   = W;
      end
      W: if (fifo_rden_o) begin
        bcnt_d  = bcnt_q + 4'd1;
        state_d = wlast_o ? B : W;
      end
      // the final response returns straight to IDLE so done rises the next cycle
      B: if (bvalid_i) begin
        err_d   = err_q | (bresp_i != 2'b00);
        addr_d  = addr_q + {25'd0, beats_q, 2'b00};
        rem_d   = rem_q - {9'd0, beats_q};
        state_d = rem_q == {9'd0, beats_q} ? IDLE : PLAN;
      end
      default: state_d = IDLE;
    endcase
  end
  // buffer level is registered; it only lags upward, so a burst is never under-buffered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      beats_q   <= '0;
      bcnt_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awvalid_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      beats_q   <= beats_d;
      bcnt_q    <= bcnt_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      awvalid_q <= awvalid_d;
      err_q     <= err_d;
      cnt_q     <= fifo_cnt_i;
    end
  end
endmodule
